// File: rtl/lenet_pkg.sv
// Shared LeNet controller constants: per-layer geometry, pipeline latencies
// and the one-hot controller state encoding.
package lenet_pkg;

  localparam int C1_FIN_W  = 32;
  localparam int C1_K      = 5;
  localparam int C1_FOUT_W = 28;

  localparam int C2_FIN_W  = 14;
  localparam int C2_K      = 5;
  localparam int C2_FOUT_W = 10;

  // Latencies shared by the conv, MAC and pool controllers
  localparam int ADDR_LAT = 3;
  localparam int RD_LAT   = 2;
  localparam int MAC_LAT  = 1;

  localparam int C2_F3_AW = 8;
  localparam int C2_W2_AW = 5;
  localparam int C2_F4_AW = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } ctrl_state_t;

endpackage

// File: rtl/conv2_ctrl_if.sv
// Sequencer / memory-side bus of the conv2 read controller.
interface conv2_ctrl_if;
  import lenet_pkg::*;

  logic                conv2_start;
  logic [C2_F3_AW-1:0] f3_raddr;
  logic [C2_W2_AW-1:0] w2_raddr;
  logic                conv2_clr;
  logic [C2_F4_AW-1:0] f4_waddr;
  logic                f4_wr_en;
  logic                conv2_done;

  modport master (
    output conv2_start,
    input  f3_raddr, w2_raddr, conv2_clr, f4_waddr, f4_wr_en, conv2_done
  );

  modport slave (
    input  conv2_start,
    output f3_raddr, w2_raddr, conv2_clr, f4_waddr, f4_wr_en, conv2_done
  );

endinterface

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register with synchronous active-high clear, used to
// align control strobes with the address/read/MAC pipeline.
module ctrl_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] q_reg;
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) q_reg <= '0;
        else     q_reg <= din;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) q_reg <= '0;
        else     q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/conv2_ctrl.sv
// conv2 read-side controller: walks a 5x5 stride-1 window over the 14x14 f3
// map, issuing f3/weight read addresses, MAC clear and f4 write strobes.
module conv2_ctrl (
  input  logic         clk,
  input  logic         rst,
  conv2_ctrl_if.slave  bus
);
  import lenet_pkg::*;

  localparam int L = ADDR_LAT + RD_LAT + MAC_LAT;

  ctrl_state_t state_reg;
  logic [2:0]  kcol_reg, krow_reg;
  logic [3:0]  ocol_reg, orow_reg;

  logic run, kcol_end, krow_end, ocol_end, orow_end;
  logic first_tap, last_tap, done_flag;

  assign run       = (state_reg == ST_RUN);
  assign kcol_end  = (kcol_reg == 3'(C2_K - 1));
  assign krow_end  = (krow_reg == 3'(C2_K - 1));
  assign ocol_end  = (ocol_reg == 4'(C2_FOUT_W - 1));
  assign orow_end  = (orow_reg == 4'(C2_FOUT_W - 1));
  assign first_tap = run && (krow_reg == 3'd0) && (kcol_reg == 3'd0);
  assign last_tap  = run && krow_end && kcol_end;
  assign done_flag = (state_reg == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      kcol_reg  <= '0;
      krow_reg  <= '0;
      ocol_reg  <= '0;
      orow_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.conv2_start) state_reg <= ST_RUN;
        ST_RUN: begin
          kcol_reg <= kcol_end ? 3'd0 : kcol_reg + 3'd1;
          if (kcol_end) begin
            krow_reg <= krow_end ? 3'd0 : krow_reg + 3'd1;
            if (krow_end) begin
              ocol_reg <= ocol_end ? 4'd0 : ocol_reg + 4'd1;
              if (ocol_end) begin
                orow_reg <= orow_end ? 4'd0 : orow_reg + 4'd1;
                if (orow_end) state_reg <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Three-stage shift-add address pipeline; each stage only loads when the
  // stage before it held a RUN tap, so addresses freeze after a run drains.
  logic [1:0] vld_reg;
  logic [3:0] s1_row_reg, s1_col_reg;
  logic [2:0] s1_krow_reg, s1_kcol_reg;
  logic [7:0] s2_row14_reg;
  logic [3:0] s2_col_reg;
  logic [4:0] s2_k5_reg;
  logic [2:0] s2_kcol_reg;
  logic [7:0] f3_raddr_reg;
  logic [4:0] w2_raddr_reg;

  logic [7:0] s1_row_ext;
  logic [4:0] s1_krow_ext;
  assign s1_row_ext  = {4'd0, s1_row_reg};
  assign s1_krow_ext = {2'd0, s1_krow_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg      <= '0;
      s1_row_reg   <= '0;
      s1_col_reg   <= '0;
      s1_krow_reg  <= '0;
      s1_kcol_reg  <= '0;
      s2_row14_reg <= '0;
      s2_col_reg   <= '0;
      s2_k5_reg    <= '0;
      s2_kcol_reg  <= '0;
      f3_raddr_reg <= '0;
      w2_raddr_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[0], run};
      if (run) begin
        s1_row_reg  <= orow_reg + {1'b0, krow_reg};
        s1_col_reg  <= ocol_reg + {1'b0, kcol_reg};
        s1_krow_reg <= krow_reg;
        s1_kcol_reg <= kcol_reg;
      end
      if (vld_reg[0]) begin
        s2_row14_reg <= (s1_row_ext << 4) - (s1_row_ext << 1);
        s2_col_reg   <= s1_col_reg;
        s2_k5_reg    <= (s1_krow_ext << 2) + s1_krow_ext;
        s2_kcol_reg  <= s1_kcol_reg;
      end
      if (vld_reg[1]) begin
        f3_raddr_reg <= s2_row14_reg + {4'd0, s2_col_reg};
        w2_raddr_reg <= s2_k5_reg + {2'd0, s2_kcol_reg};
      end
    end
  end

  assign bus.f3_raddr = f3_raddr_reg;
  assign bus.w2_raddr = w2_raddr_reg;

  logic [6:0] orow_ext, f4_addr_now;
  assign orow_ext    = {3'd0, orow_reg};
  assign f4_addr_now = (orow_ext << 3) + (orow_ext << 1) + {3'd0, ocol_reg};

  ctrl_delay_line #(.WIDTH(1), .DEPTH(ADDR_LAT + RD_LAT)) u_clr_dly (
    .clk(clk), .rst(rst), .din(first_tap), .dout(bus.conv2_clr)
  );

  ctrl_delay_line #(.WIDTH(1), .DEPTH(L)) u_wr_dly (
    .clk(clk), .rst(rst), .din(last_tap), .dout(bus.f4_wr_en)
  );

  ctrl_delay_line #(.WIDTH(7), .DEPTH(L)) u_waddr_dly (
    .clk(clk), .rst(rst), .din(f4_addr_now), .dout(bus.f4_waddr)
  );

  ctrl_delay_line #(.WIDTH(1), .DEPTH(L)) u_done_dly (
    .clk(clk), .rst(rst), .din(done_flag), .dout(bus.conv2_done)
  );

endmodule
